proc_hier_core: RTL and testbench
=================================

Name: proc_hier_core

Overview:
- Single-cycle 16-bit processor top, byte-addressed, with eight 16-bit GPRs.
- External instruction and data memories attach through ports.
- Exports a per-cycle retirement trace (PC, instruction, register write, memory access, halt) and a cycle counter, so the system bench can log one retired instruction per clock.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- imem_addr  out  16  current PC.
- imem_data  in  16  instruction at imem_addr, combinational.
- dmem_addr  out  16  ALU result, used as memory address.
- dmem_wdata  out  16  second register-read value (store data).
- dmem_rdata  in  16  load data, combinational read.
- dmem_rd_en  out  1  load in progress.
- dmem_wr_en  out  1  store in progress; memory writes on the clk edge.
- pc  out  16  trace: PC of the current instruction.
- inst  out  16  trace: current instruction.
- reg_wr_en  out  1  trace and regfile write enable.
- write_reg  out  3  destination register.
- write_data  out  16  data written to the register.
- halt  out  1  current instruction is HALT.
- cycle_count  out  32  cycles since reset release.

Behaviour:
- Reset (rst=0 at clk edge):
  - PC <= RESET_PC; all GPRs <= 0; cycle_count <= 0.
  - Combinational outputs follow the instruction at RESET_PC.
- Out of reset: cycle_count += 1 every edge, including while halted; wraps at 2^32.
- One instruction per cycle.
  - Register and memory writes commit on the edge ending that cycle.
  - Reads return pre-write values; no bypass.
- Encoding: op=[15:11], Rs=[10:8], Rt=[7:5], Rd I-form=[7:5], Rd R-form=[4:2], fn=[1:0].
  - imm5=[4:0], imm8=[7:0], imm11=[10:0], all sign-extended.
- Default next PC = PC+2, 16-bit wrap.
- Instructions:
  - 00000 HALT: halt=1; PC holds; no writes. Stays halted until reset.
  - 00001 NOP: no writes.
  - 01000 ADDI: Rd=Rs+imm5.
  - 01001 SUBI: Rd=Rs-imm5.
  - 11011 R-type:
    - fn 00 ADD Rd=Rs+Rt
    - fn 01 SUB Rd=Rs-Rt
    - fn 10 AND Rd=Rs&Rt
    - fn 11 XOR Rd=Rs^Rt
  - 11000 LBI: R[Rs]=imm8 (write_reg=Rs).
  - 10001 LD: Rd=MEM[Rs+imm5]; dmem_rd_en=1.
  - 10000 ST: MEM[Rs+imm5]=R[Rd]; dmem_wr_en=1; reg_wr_en=0.
  - 10011 STU: MEM[Rs+imm5]=R[Rd] and R[Rs]=Rs+imm5; dmem_wr_en=1 and reg_wr_en=1 in the same cycle.
  - 01100 BEQZ: if R[Rs]==0, PC=PC+2+imm8, else PC+2.
  - 00100 J: PC=PC+2+imm11.
  - Any other opcode behaves as NOP.
- Arithmetic is 16-bit two's complement, carry discarded; no flags.
- dmem_addr = ALU result every cycle.
- dmem_wdata = second register-read port every cycle: R[Rd] field for ST/STU, R[Rt] otherwise.
- write_data/write_reg/reg_wr_en are meaningful only when reg_wr_en=1.
  - When reg_wr_en=0, write_data shows the ALU result and write_reg shows the decoded destination.
- R0 is a normal writable register.

Decomposition:
- Package proc_hier_pkg:
  - 5-bit opcode localparams and 2-bit fn codes.
  - Width constants: XLEN=16, NREG=8.
- Sub-module proc_regfile:
  - 8x16 array, 2 async read ports, 1 sync write port.
  - Synchronous active-low clear.
- Decoder, ALU and next-PC logic stay inline in proc_hier_core.

Test Plan:
- Reset held 2 cycles, then program "LBI r1,5; ADDI r2,r1,-3; HALT" -> reg_wr_en=1 with write_reg=1/write_data=0x0005, then write_reg=2/write_data=0x0002; then halt=1 at pc=0x0004, pc frozen, cycle_count keeps incrementing.
- With r1=0x0010, r3=0xBEEF: "ST r3,r1,2" then "LD r4,r1,2":
  - ST cycle: dmem_wr_en=1, dmem_addr=0x0012, dmem_wdata=0xBEEF.
  - LD cycle: dmem_rd_en=1, write_reg=4, write_data=0xBEEF.
- STU r3,r1,-2 with r1=0x0010 -> dmem_wr_en=1 and reg_wr_en=1 together; dmem_addr=0x000E; r1=0x000E afterwards.
- BEQZ r5,+4 at pc 0x0008:
  - r5=0 -> next pc 0x000E, reg_wr_en=0 and dmem_wr_en=0.
  - r5=1 -> next pc 0x000A.
- R-type wrap: r1=0x7FFF, ADD r2,r1,r1 -> 0xFFFE; SUB r3,r1,r1 -> 0x0000; XOR 0x00FF^0xFFFF -> 0xFF00.
- rst driven low mid-program -> next edge pc=0x0000, all regs read 0, cycle_count=0; execution resumes from 0 after release.

Source files
------------

// File: rtl/proc_hier_pkg.sv
// Shared constants for the single-cycle 16-bit core: opcodes, R-type
// function codes and datapath widths.
package proc_hier_pkg;
    localparam int XLEN = 16;
    localparam int NREG = 8;
    localparam int RW   = $clog2(NREG);

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_RTYPE = 5'b11011;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_J     = 5'b00100;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_XOR = 2'b11;
endpackage

// File: rtl/proc_hier_core_if.sv
// Instruction/data memory attachment; the core is master, memories are slave.
interface proc_hier_core_if;
    import proc_hier_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_rd_en;
    logic            dmem_wr_en;

    modport master (output imem_addr, dmem_addr, dmem_wdata, dmem_rd_en, dmem_wr_en,
                    input  imem_data, dmem_rdata);
    modport slave  (input  imem_addr, dmem_addr, dmem_wdata, dmem_rd_en, dmem_wr_en,
                    output imem_data, dmem_rdata);
endinterface

// File: rtl/proc_regfile.sv
// 8x16 register file: two async read ports, one sync write port, sync clear.
module proc_regfile
    import proc_hier_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // Reads see the pre-write contents; no write-through bypass.
    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

    always_comb begin
        for (int i = 0; i < NREG; i++) mem_d[i] = mem_q[i];
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst) mem_q[i] <= '0;
            else      mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: rtl/proc_hier_core.sv
// Single-cycle 16-bit core with inline decode/ALU/next-PC, a register file
// sub-block and a per-cycle retirement trace.
module proc_hier_core
    import proc_hier_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    proc_hier_core_if.master mem,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  inst,
    output logic             reg_wr_en,
    output logic [RW-1:0]    write_reg,
    output logic [XLEN-1:0]  write_data,
    output logic             halt,
    output logic [31:0]      cycle_count
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [4:0]      op;
    logic [XLEN-1:0] imm5, imm8, imm11, rs_val, rt_val, alu, pc_inc;
    logic            rd_en, wr_en;

    assign inst   = mem.imem_data;
    assign op     = inst[15:11];
    assign imm5   = {{11{inst[4]}}, inst[4:0]};
    assign imm8   = {{8{inst[7]}}, inst[7:0]};
    assign imm11  = {{5{inst[10]}}, inst[10:0]};
    assign pc_inc = pc_q + 16'd2;

    // Port 2 address [7:5] is Rt for R-type and the store-data Rd for ST/STU.
    proc_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_wr_en),
        .waddr  (write_reg),
        .wdata  (write_data),
        .raddr1 (inst[10:8]),
        .rdata1 (rs_val),
        .raddr2 (inst[7:5]),
        .rdata2 (rt_val)
    );

    always_comb begin
        alu       = rs_val + imm5;
        write_reg = inst[7:5];
        reg_wr_en = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        halt      = 1'b0;
        pc_d      = pc_inc;
        case (op)
            OP_HALT: begin halt = 1'b1; pc_d = pc_q; end
            OP_NOP:  ;
            OP_ADDI: reg_wr_en = 1'b1;
            OP_SUBI: begin alu = rs_val - imm5; reg_wr_en = 1'b1; end
            OP_RTYPE: begin
                write_reg = inst[4:2];
                reg_wr_en = 1'b1;
                case (inst[1:0])
                    FN_ADD:  alu = rs_val + rt_val;
                    FN_SUB:  alu = rs_val - rt_val;
                    FN_AND:  alu = rs_val & rt_val;
                    FN_XOR:  alu = rs_val ^ rt_val;
                    default: alu = rs_val + rt_val;
                endcase
            end
            OP_LBI:  begin alu = imm8; write_reg = inst[10:8]; reg_wr_en = 1'b1; end
            OP_LD:   begin rd_en = 1'b1; reg_wr_en = 1'b1; end
            OP_ST:   wr_en = 1'b1;
            OP_STU:  begin wr_en = 1'b1; write_reg = inst[10:8]; reg_wr_en = 1'b1; end
            OP_BEQZ: if (rs_val == '0) pc_d = pc_inc + imm8;
            OP_J:    pc_d = pc_inc + imm11;
            default: ;
        endcase
        write_data = rd_en ? mem.dmem_rdata : alu;
        cycle_d    = cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            cycle_q <= '0;
        end else begin
            pc_q    <= pc_d;
            cycle_q <= cycle_d;
        end
    end

    assign pc             = pc_q;
    assign cycle_count    = cycle_q;
    assign mem.imem_addr  = pc_q;
    assign mem.dmem_addr  = alu;
    assign mem.dmem_wdata = rt_val;
    assign mem.dmem_rd_en = rd_en;
    assign mem.dmem_wr_en = wr_en;
endmodule

// File: tb/tb_proc_hier_core.sv
// Directed bench: three short programs in a behavioural imem/dmem, checked at negedge.
module tb_proc_hier_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, inst, write_data;
    logic        reg_wr_en, halt;
    logic [2:0]  write_reg;
    logic [31:0] cycle_count;
    int          total = 0;
    int          bad   = 0;

    logic [15:0] imem [0:63];
    logic [15:0] dmem [0:63];

    proc_hier_core_if mif();

    proc_hier_core #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem(mif.master),
        .pc(pc), .inst(inst), .reg_wr_en(reg_wr_en), .write_reg(write_reg),
        .write_data(write_data), .halt(halt), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign mif.imem_data  = imem[mif.imem_addr[6:1]];
    assign mif.dmem_rdata = dmem[mif.dmem_addr[6:1]];
    always @(posedge clk) if (mif.dmem_wr_en) dmem[mif.dmem_addr[6:1]] <= mif.dmem_wdata;

    function automatic logic [15:0] e_lbi(input logic [2:0] rs, input logic [7:0] i8);
        return {5'b11000, rs, i8};
    endfunction
    function automatic logic [15:0] e_i(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [4:0] i5);
        return {op, rs, rd, i5};
    endfunction
    function automatic logic [15:0] e_r(input logic [1:0] fn, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {5'b11011, rs, rt, rd, fn};
    endfunction
    function automatic logic [15:0] e_beqz(input logic [2:0] rs, input logic [7:0] i8);
        return {5'b01100, rs, i8};
    endfunction
    function automatic logic [15:0] e_j(input logic [10:0] i11);
        return {5'b00100, i11};
    endfunction

    localparam logic [15:0] I_HALT = 16'h0000;
    localparam logic [15:0] I_NOP  = 16'h0800;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem[i] = I_HALT;
            dmem[i] = 16'h0000;
        end
    endtask

    initial begin
        // Session A: reset held two cycles, LBI/ADDI/HALT
        rst = 1'b0;
        clear_mem();
        imem[0] = e_lbi(3'd1, 8'd5);
        imem[1] = e_i(5'b01000, 3'd2, 3'd1, 5'h1D);
        imem[2] = I_HALT;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_cycle", cycle_count, 32'd0);
        chk("a_lbi_we", reg_wr_en, 1'b1);
        chk("a_lbi_reg", write_reg, 3'd1);
        chk("a_lbi_data", write_data, 16'h0005);
        rst = 1'b1;
        tick();
        chk("a_addi_pc", pc, 16'h0002);
        chk("a_addi_reg", write_reg, 3'd2);
        chk("a_addi_data", write_data, 16'h0002);
        chk("a_cycle1", cycle_count, 32'd1);
        tick();
        chk("a_halt", halt, 1'b1);
        chk("a_halt_pc", pc, 16'h0004);
        chk("a_halt_we", reg_wr_en, 1'b0);
        repeat (3) tick();
        chk("a_halt_pc_frozen", pc, 16'h0004);
        chk("a_halt_still", halt, 1'b1);
        chk("a_cycle_runs", cycle_count, 32'd5);

        // Session B: loads, stores, STU, mid-program reset
        rst = 1'b0;
        clear_mem();
        dmem[16] = 16'hBEEF;
        imem[0] = e_lbi(3'd1, 8'h10);
        imem[1] = e_lbi(3'd6, 8'h20);
        imem[2] = e_i(5'b10001, 3'd3, 3'd6, 5'd0);   // LD r3,r6,0
        imem[3] = e_i(5'b10000, 3'd3, 3'd1, 5'd2);   // ST r3,r1,2
        imem[4] = e_i(5'b10001, 3'd4, 3'd1, 5'd2);   // LD r4,r1,2
        imem[5] = e_i(5'b10011, 3'd3, 3'd1, 5'h1E);  // STU r3,r1,-2
        imem[6] = e_i(5'b01000, 3'd7, 3'd1, 5'd0);   // ADDI r7,r1,0
        tick();
        rst = 1'b1;
        chk("b_lbi_data", write_data, 16'h0010);
        tick();
        tick();
        chk("b_ld0_rd", mif.dmem_rd_en, 1'b1);
        chk("b_ld0_addr", mif.dmem_addr, 16'h0020);
        chk("b_ld0_data", write_data, 16'hBEEF);
        tick();
        chk("b_st_wr", mif.dmem_wr_en, 1'b1);
        chk("b_st_we", reg_wr_en, 1'b0);
        chk("b_st_addr", mif.dmem_addr, 16'h0012);
        chk("b_st_wdata", mif.dmem_wdata, 16'hBEEF);
        tick();
        chk("b_ld_rd", mif.dmem_rd_en, 1'b1);
        chk("b_ld_reg", write_reg, 3'd4);
        chk("b_ld_data", write_data, 16'hBEEF);
        tick();
        chk("b_stu_wr", mif.dmem_wr_en, 1'b1);
        chk("b_stu_we", reg_wr_en, 1'b1);
        chk("b_stu_addr", mif.dmem_addr, 16'h000E);
        chk("b_stu_reg", write_reg, 3'd1);
        chk("b_stu_data", write_data, 16'h000E);
        tick();
        chk("b_r1_after_stu", write_data, 16'h000E);
        chk("b_stu_mem", dmem[7], 16'hBEEF);
        chk("b_cycle6", cycle_count, 32'd6);
        rst = 1'b0;
        tick();
        chk("b_mrst_pc", pc, 16'h0000);
        chk("b_mrst_cycle", cycle_count, 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("b_mrst_r%0d", i), dut.u_rf.mem_q[i], 16'h0000);
        rst = 1'b1;
        chk("b_resume_data", write_data, 16'h0010);
        tick();
        chk("b_resume_pc", pc, 16'h0002);
        chk("b_resume_data2", write_data, 16'h0020);
        chk("b_resume_cycle", cycle_count, 32'd1);

        // Session C: branches, jumps, R-type wrap
        rst = 1'b0;
        clear_mem();
        dmem[0] = 16'h7FFF;
        dmem[1] = 16'h00FF;
        imem[0]  = e_lbi(3'd5, 8'd0);
        imem[1]  = I_NOP;
        imem[2]  = I_NOP;
        imem[3]  = I_NOP;
        imem[4]  = e_beqz(3'd5, 8'd4);               // 0x08
        imem[5]  = e_j(11'd8);                       // 0x0A -> 0x14
        imem[6]  = I_HALT;
        imem[7]  = e_lbi(3'd5, 8'd1);                // 0x0E
        imem[8]  = e_j(11'h7F6);                     // 0x10 -> 0x08
        imem[10] = e_i(5'b10001, 3'd1, 3'd0, 5'd0);  // 0x14 LD r1
        imem[11] = e_r(2'b00, 3'd2, 3'd1, 3'd1);     // ADD r2,r1,r1
        imem[12] = e_r(2'b01, 3'd3, 3'd1, 3'd1);     // SUB r3,r1,r1
        imem[13] = e_lbi(3'd4, 8'hFF);
        imem[14] = e_i(5'b10001, 3'd6, 3'd0, 5'd2);  // LD r6
        imem[15] = e_r(2'b11, 3'd7, 3'd6, 3'd4);     // XOR r7,r6,r4
        imem[16] = e_r(2'b10, 3'd7, 3'd6, 3'd4);     // AND r7,r6,r4
        imem[17] = I_HALT;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("c_beqz_pc", pc, 16'h0008);
        chk("c_beqz_we", reg_wr_en, 1'b0);
        chk("c_beqz_wr", mif.dmem_wr_en, 1'b0);
        tick();
        chk("c_beqz_taken", pc, 16'h000E);
        tick();
        tick();
        chk("c_j_back", pc, 16'h0008);
        tick();
        chk("c_beqz_not_taken", pc, 16'h000A);
        tick();
        chk("c_j_fwd", pc, 16'h0014);
        tick();
        chk("c_add_reg", write_reg, 3'd2);
        chk("c_add_wrap", write_data, 16'hFFFE);
        tick();
        chk("c_sub_reg", write_reg, 3'd3);
        chk("c_sub_zero", write_data, 16'h0000);
        tick();
        chk("c_lbi_sext", write_data, 16'hFFFF);
        tick();
        tick();
        chk("c_xor", write_data, 16'hFF00);
        tick();
        chk("c_and", write_data, 16'h00FF);
        tick();
        chk("c_halt", halt, 1'b1);
        chk("c_halt_pc", pc, 16'h0022);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
